// File: rtl/vip_flow_control_input_fifo.sv
// Video input stage: filters active video into a FIFO, holds decoder control until earlier video drains.
// Write-to-head 1 cycle, control release 1 cycle after empty; din_ready drops for video when full or control pending.
module vip_flow_control_input_fifo #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3,
   parameter int FIFO_DEPTH       = 4,
   localparam int DATA_W          = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
   localparam int AW              = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              din_ready,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din_data,
   input  logic [15:0]       decoder_width,
   input  logic [15:0]       decoder_height,
   input  logic [3:0]        decoder_interlaced,
   input  logic              decoder_end_of_video,
   input  logic              decoder_is_video,
   input  logic              decoder_vip_ctrl_valid,
   output logic [DATA_W-1:0] data_in,
   output logic              end_of_video_in,
   output logic [15:0]       width_in,
   output logic [15:0]       height_in,
   output logic [3:0]        interlaced_in,
   output logic              vip_ctrl_valid_in,
   input  logic              read,
   output logic              stall_in,
   output logic [AW:0]       fifo_level
);

   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              ctrl_pending;
   logic [15:0]       pend_width;
   logic [15:0]       pend_height;
   logic [3:0]        pend_interlaced;

   logic full;
   logic empty;
   logic wr;
   logic rd;

   assign full  = (count == DEPTH);
   assign empty = (count == '0);

   // Video is held off while control is pending so control and video stay ordered.
   assign din_ready = ~rst & (~decoder_is_video | (~full & ~ctrl_pending));
   assign wr        = din_valid & decoder_is_video & ~full & ~ctrl_pending;
   assign rd        = read & ~empty;

   assign data_in         = mem[rd_ptr][DATA_W-1:0];
   assign end_of_video_in = mem[rd_ptr][DATA_W];
   assign stall_in        = empty;
   assign fifo_level      = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= {decoder_end_of_video, din_data};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      end
   end

   // A fresh capture always wins over a release in the same cycle; release then follows a cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_pending      <= 1'b0;
         pend_width        <= '0;
         pend_height       <= '0;
         pend_interlaced   <= '0;
         width_in          <= '0;
         height_in         <= '0;
         interlaced_in     <= '0;
         vip_ctrl_valid_in <= 1'b0;
      end else if (decoder_vip_ctrl_valid) begin
         ctrl_pending      <= 1'b1;
         pend_width        <= decoder_width;
         pend_height       <= decoder_height;
         pend_interlaced   <= decoder_interlaced;
         vip_ctrl_valid_in <= 1'b0;
      end else if (ctrl_pending && empty) begin
         ctrl_pending      <= 1'b0;
         width_in          <= pend_width;
         height_in         <= pend_height;
         interlaced_in     <= pend_interlaced;
         vip_ctrl_valid_in <= 1'b1;
      end else begin
         vip_ctrl_valid_in <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vip_flow_control_input_fifo.sv
// Scoreboard bench: stimulus queues expected head beats and control packets, a negedge monitor compares them.
module tb_vip_flow_control_input_fifo;

   localparam int DATA_W = 24;

   logic              clk = 1'b0;
   logic              rst;
   logic              din_ready;
   logic              din_valid;
   logic [DATA_W-1:0] din_data;
   logic [15:0]       decoder_width;
   logic [15:0]       decoder_height;
   logic [3:0]        decoder_interlaced;
   logic              decoder_end_of_video;
   logic              decoder_is_video;
   logic              decoder_vip_ctrl_valid;
   logic [DATA_W-1:0] data_in;
   logic              end_of_video_in;
   logic [15:0]       width_in;
   logic [15:0]       height_in;
   logic [3:0]        interlaced_in;
   logic              vip_ctrl_valid_in;
   logic              read;
   logic              stall_in;
   logic [2:0]        fifo_level;

   int checks = 0;
   int errors = 0;

   logic [DATA_W:0] beat_q [$];
   logic [35:0]     ctrl_q [$];

   vip_flow_control_input_fifo #(
      .BITS_PER_SYMBOL (8),
      .SYMBOLS_PER_BEAT(3),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .din_ready             (din_ready),
      .din_valid             (din_valid),
      .din_data              (din_data),
      .decoder_width         (decoder_width),
      .decoder_height        (decoder_height),
      .decoder_interlaced    (decoder_interlaced),
      .decoder_end_of_video  (decoder_end_of_video),
      .decoder_is_video      (decoder_is_video),
      .decoder_vip_ctrl_valid(decoder_vip_ctrl_valid),
      .data_in               (data_in),
      .end_of_video_in       (end_of_video_in),
      .width_in              (width_in),
      .height_in             (height_in),
      .interlaced_in         (interlaced_in),
      .vip_ctrl_valid_in     (vip_ctrl_valid_in),
      .read                  (read),
      .stall_in              (stall_in),
      .fifo_level            (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the next edge whenever read is high and the head is valid.
   always @(negedge clk) begin
      if (!rst && read && !stall_in) begin
         if (beat_q.size() == 0) begin
            chk("unexpected_pop", {end_of_video_in, data_in}, 64'hDEAD);
         end else begin
            chk("head_beat", {end_of_video_in, data_in}, beat_q.pop_front());
         end
      end
      if (vip_ctrl_valid_in) begin
         if (ctrl_q.size() == 0) begin
            chk("unexpected_ctrl_pulse", {width_in, height_in, interlaced_in}, 64'hDEAD);
         end else begin
            chk("ctrl_fields", {width_in, height_in, interlaced_in}, ctrl_q.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      din_valid              = 1'b0;
      din_data               = '0;
      decoder_is_video       = 1'b0;
      decoder_end_of_video   = 1'b0;
      decoder_vip_ctrl_valid = 1'b0;
   endtask

   // Present one video beat that is known to be accepted this cycle.
   task automatic put_video(input logic [DATA_W-1:0] d, input logic eov, input logic expect_out);
      din_valid            = 1'b1;
      decoder_is_video     = 1'b1;
      din_data             = d;
      decoder_end_of_video = eov;
      @(negedge clk);
      chk("din_ready_accept", din_ready, 1'b1);
      if (expect_out) beat_q.push_back({eov, d});
      cyc();
      idle_inputs();
   endtask

   task automatic ctrl_pulse(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
      decoder_vip_ctrl_valid = 1'b1;
      decoder_width          = w;
      decoder_height         = h;
      decoder_interlaced     = il;
      cyc();
      decoder_vip_ctrl_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      read = 1'b1;
      repeat (n) cyc();
      read = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      read = 1'b0;
      decoder_width = '0;
      decoder_height = '0;
      decoder_interlaced = '0;
      idle_inputs();
      decoder_is_video = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall_in", stall_in, 1'b1);
      chk("rst_fifo_level", fifo_level, 3'd0);
      chk("rst_din_ready", din_ready, 1'b0);
      chk("rst_data_in", {end_of_video_in, data_in}, '0);
      chk("rst_ctrl_out", {vip_ctrl_valid_in, width_in, height_in, interlaced_in}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      decoder_is_video = 1'b0;

      // Fill to full, 5th beat refused, then drain in order.
      for (int i = 1; i <= 4; i++) put_video(DATA_W'(i), 1'b0, 1'b1);
      din_valid = 1'b1; decoder_is_video = 1'b1; din_data = 24'h5;
      @(negedge clk);
      chk("full_din_ready", din_ready, 1'b0);
      chk("full_level", fifo_level, 3'd4);
      cyc();
      idle_inputs();
      drain(4);
      @(negedge clk);
      chk("drained_stall", stall_in, 1'b1);
      chk("drained_level", fifo_level, 3'd0);
      cyc();

      // Full with read high: ready stays low this cycle and rises after the pop.
      for (int i = 0; i < 4; i++) put_video(24'h10 + DATA_W'(i), 1'b0, 1'b1);
      read = 1'b1; din_valid = 1'b1; decoder_is_video = 1'b1; din_data = 24'h14;
      @(negedge clk);
      chk("full_read_din_ready", din_ready, 1'b0);
      cyc();
      @(negedge clk);
      chk("after_pop_din_ready", din_ready, 1'b1);
      beat_q.push_back({1'b0, 24'h14});
      cyc();
      idle_inputs();
      repeat (5) cyc();
      read = 1'b0;
      @(negedge clk);
      chk("full_read_level", fifo_level, 3'd0);
      cyc();

      // Non-video beats interleaved are accepted but never stored.
      put_video(24'h21, 1'b0, 1'b1);
      din_valid = 1'b1; decoder_is_video = 1'b0; din_data = 24'hAA;
      @(negedge clk); chk("nonvideo_ready_a", din_ready, 1'b1); cyc();
      put_video(24'h22, 1'b0, 1'b1);
      din_valid = 1'b1; decoder_is_video = 1'b0; din_data = 24'hBB;
      @(negedge clk); chk("nonvideo_ready_b", din_ready, 1'b1); cyc();
      put_video(24'h23, 1'b0, 1'b1);
      @(negedge clk);
      chk("nonvideo_level", fifo_level, 3'd3);
      cyc();
      drain(3);

      // Streaming with read held high, end_of_video on the third beat.
      read = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         din_valid = 1'b1; decoder_is_video = 1'b1;
         din_data = 24'h30 + DATA_W'(i);
         decoder_end_of_video = (i == 3);
         beat_q.push_back({decoder_end_of_video, din_data});
         @(negedge clk);
         chk("stream_ready", din_ready, 1'b1);
         chk("stream_level_le1", fifo_level <= 3'd1, 1'b1);
         cyc();
      end
      idle_inputs();
      repeat (2) cyc();
      read = 1'b0;

      // Control waits behind buffered video.
      put_video(24'h41, 1'b0, 1'b1);
      put_video(24'h42, 1'b1, 1'b1);
      ctrl_q.push_back({16'd640, 16'd480, 4'd0});
      ctrl_pulse(16'd640, 16'd480, 4'd0);
      din_valid = 1'b1; decoder_is_video = 1'b1; din_data = 24'h43;
      read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("ctrl_pend_din_ready", din_ready, 1'b0);
         chk("ctrl_pend_no_pulse", vip_ctrl_valid_in, 1'b0);
         cyc();
      end
      read = 1'b0;
      @(negedge clk);
      chk("ctrl_release_wait_ready", din_ready, 1'b0);
      chk("ctrl_release_wait_pulse", vip_ctrl_valid_in, 1'b0);
      cyc();
      @(negedge clk);
      chk("ctrl_pulse_seen", vip_ctrl_valid_in, 1'b1);
      chk("ctrl_after_din_ready", din_ready, 1'b1);
      beat_q.push_back({1'b0, 24'h43});
      cyc();
      idle_inputs();
      @(negedge clk);
      chk("ctrl_pulse_one_cycle", vip_ctrl_valid_in, 1'b0);
      chk("post_ctrl_level", fifo_level, 3'd1);
      cyc();
      drain(1);

      // Back-to-back captures: only the latest is released.
      ctrl_pulse(16'd720, 16'd576, 4'd1);
      ctrl_pulse(16'd1280, 16'd720, 4'd2);
      ctrl_q.push_back({16'd1280, 16'd720, 4'd2});
      repeat (4) cyc();
      chk("overwrite_width", width_in, 16'd1280);

      // Reset with buffered beats and pending control.
      for (int i = 1; i <= 3; i++) put_video(24'h50 + DATA_W'(i), 1'b0, 1'b0);
      ctrl_pulse(16'd800, 16'd600, 4'd0);
      rst = 1'b1;
      decoder_is_video = 1'b1;
      @(negedge clk);
      chk("mid_rst_stall", stall_in, 1'b1);
      chk("mid_rst_level", fifo_level, 3'd0);
      chk("mid_rst_width", width_in, 16'd0);
      chk("mid_rst_din_ready", din_ready, 1'b0);
      cyc();
      rst = 1'b0;
      decoder_is_video = 1'b0;
      repeat (4) cyc();
      @(negedge clk);
      chk("post_rst_stall", stall_in, 1'b1);
      chk("post_rst_level", fifo_level, 3'd0);
      chk("post_rst_width", width_in, 16'd0);

      chk("beats_left", beat_q.size(), 0);
      chk("ctrl_left", ctrl_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
